// File: rtl/serial_rx4.sv
// serial_rx4 -- non-oversampled serial frame receiver.
// Frame: start(0), WIDTH data bits, optional even parity, stop(1); one bit per clk.
// Each received word is held on A with a valid/ack handshake. A good frame
// that arrives while an unconsumed word is still held is dropped and flagged
// by the sticky overrun output.
module serial_rx4 #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             S_in,
  input  logic             dir,
  input  logic             ack,
  output logic [WIDTH-1:0] A,
  output logic             valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA      = 3'd1;
  localparam logic [2:0] PARITY    = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [2:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             dir_reg;
  logic             bad_reg;

  // Next shift-register contents for each bit order.
  logic [WIDTH-1:0] lsb_first_next;
  logic [WIDTH-1:0] msb_first_next;
  logic [WIDTH-1:0] shift_next;

  // LSB-first: new bit enters at the top and moves down toward bit 0.
  // MSB-first: new bit enters at bit 0 and moves up toward the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign lsb_first_next[gi] = S_in;
      end else begin : g_mid_l
        assign lsb_first_next[gi] = shift_reg[gi+1];
      end
      if (gi == 0) begin : g_bot
        assign msb_first_next[gi] = S_in;
      end else begin : g_mid_m
        assign msb_first_next[gi] = shift_reg[gi-1];
      end
    end
  endgenerate

  assign shift_next = dir_reg ? msb_first_next : lsb_first_next;

  // A frame is good when the stop bit is high and no parity mismatch was seen.
  logic stop_ok;
  logic good_frame;
  assign stop_ok    = (state_reg == STOP) && S_in;
  assign good_frame = stop_ok && !bad_reg;

  // Frame-level state machine: start detection, data shift, parity, stop.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      dir_reg   <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!S_in) begin
            dir_reg   <= dir;
            cnt_reg   <= '0;
            shift_reg <= '0;
            bad_reg   <= 1'b0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          // Even parity: data bits XOR parity bit must be 0.
          bad_reg   <= (^shift_reg) ^ S_in;
          state_reg <= STOP;
        end
        STOP: begin
          state_reg <= S_in ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (S_in) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output word, handshake, error pulses and sticky overrun.
  always_ff @(posedge clk) begin
    if (clear) begin
      A       <= '0;
      valid   <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      par_err <= stop_ok && bad_reg;
      frm_err <= (state_reg == STOP) && !S_in;
      if (valid && ack) begin
        valid <= 1'b0;
      end
      if (good_frame) begin
        if (!valid || ack) begin
          A     <= shift_reg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx4.sv
// Directed bench for serial_rx4 (WIDTH=4, PARITY_EN=1).
// Frames are written as 7-bit vectors, leftmost bit sent first (start .. stop).
module tb_serial_rx4;

  logic       clk = 1'b0;
  logic       clear;
  logic       S_in;
  logic       dir;
  logic       ack;
  logic [3:0] A;
  logic       valid;
  logic       par_err;
  logic       frm_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_frame = 0;

  serial_rx4 #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk     (clk),
    .clear   (clear),
    .S_in    (S_in),
    .dir     (dir),
    .ack     (ack),
    .A       (A),
    .valid   (valid),
    .par_err (par_err),
    .frm_err (frm_err),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    S_in = b;
    tick();
  endtask

  // dir is applied only during the start bit and inverted afterwards, so a
  // receiver that fails to latch it produces the wrong word.
  task automatic send_frame(input logic [6:0] bits, input logic d, input logic ack_stop);
    logic [6:0] f;
    f = bits;
    dir = d;
    send_bit(f[6]);
    dir = ~d;
    for (int i = 5; i >= 1; i--) send_bit(f[i]);
    ack = ack_stop;
    send_bit(f[0]);
    ack = 1'b0;
    n_frame++;
    $display("frame %0d: bits=%b dir=%0d ack_on_stop=%0d -> A=%b valid=%0d par_err=%0d frm_err=%0d overrun=%0d",
             n_frame, f, d, ack_stop, A, valid, par_err, frm_err, overrun);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1;
    S_in  = 1'b1;
    dir   = 1'b0;
    ack   = 1'b0;
    tick();
    tick();
    check("rst_A", 16'(A), 16'h0);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_par_err", 16'(par_err), 16'h0);
    check("rst_frm_err", 16'(frm_err), 16'h0);
    check("rst_overrun", 16'(overrun), 16'h0);
    clear = 1'b0;
    send_bit(1'b1);

    // LSB-first good frame
    send_frame(7'b0010101, 1'b0, 1'b0);
    check("lsb_A", 16'(A), 16'hA);
    check("lsb_valid", 16'(valid), 16'h1);
    check("lsb_par_err", 16'(par_err), 16'h0);
    check("lsb_frm_err", 16'(frm_err), 16'h0);
    ack = 1'b1;
    send_bit(1'b1);
    ack = 1'b0;
    check("ack_valid_low", 16'(valid), 16'h0);
    check("ack_A_kept", 16'(A), 16'hA);

    // MSB-first, same data bits
    send_frame(7'b0010101, 1'b1, 1'b0);
    check("msb_A", 16'(A), 16'h5);
    check("msb_valid", 16'(valid), 16'h1);

    // Bad parity while a word is held
    send_frame(7'b0100001, 1'b0, 1'b0);
    check("par_pulse", 16'(par_err), 16'h1);
    check("par_frm_err", 16'(frm_err), 16'h0);
    check("par_A_kept", 16'(A), 16'h5);
    check("par_valid_kept", 16'(valid), 16'h1);
    check("par_no_overrun", 16'(overrun), 16'h0);
    send_bit(1'b1);
    check("par_pulse_end", 16'(par_err), 16'h0);

    // Framing error, line stays low three cycles
    send_frame(7'b0101000, 1'b0, 1'b0);
    check("frm_pulse", 16'(frm_err), 16'h1);
    check("frm_no_par_err", 16'(par_err), 16'h0);
    check("frm_A_kept", 16'(A), 16'h5);
    send_bit(1'b0);
    check("frm_pulse_end", 16'(frm_err), 16'h0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("wait_no_err", 16'({par_err, frm_err}), 16'h0);
    send_bit(1'b1);
    ack = 1'b1;
    send_bit(1'b1);
    ack = 1'b0;
    check("wait_ack_valid", 16'(valid), 16'h0);
    send_frame(7'b0001101, 1'b0, 1'b0);
    check("after_wait_A", 16'(A), 16'hC);
    check("after_wait_valid", 16'(valid), 16'h1);
    check("after_wait_errs", 16'({par_err, frm_err}), 16'h0);
    ack = 1'b1;
    send_bit(1'b1);
    ack = 1'b0;

    // Overrun: two good frames back-to-back without ack
    send_frame(7'b0010101, 1'b0, 1'b0);
    check("ovr1_A", 16'(A), 16'hA);
    check("ovr1_overrun", 16'(overrun), 16'h0);
    send_frame(7'b0110001, 1'b0, 1'b0);
    check("ovr2_A_kept", 16'(A), 16'hA);
    check("ovr2_valid", 16'(valid), 16'h1);
    check("ovr2_overrun", 16'(overrun), 16'h1);
    ack = 1'b1;
    send_bit(1'b1);
    ack = 1'b0;
    check("ovr_ack_valid", 16'(valid), 16'h0);
    check("ovr_sticky", 16'(overrun), 16'h1);

    // Clear drops the sticky flag
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    check("clr_overrun", 16'(overrun), 16'h0);
    check("clr_A", 16'(A), 16'h0);

    // Ack in the exact cycle the second frame completes
    send_frame(7'b0010101, 1'b0, 1'b0);
    check("same1_A", 16'(A), 16'hA);
    send_frame(7'b0110001, 1'b0, 1'b1);
    check("same2_A", 16'(A), 16'h3);
    check("same2_valid", 16'(valid), 16'h1);
    check("same2_overrun", 16'(overrun), 16'h0);
    send_bit(1'b1);
    check("same2_valid_held", 16'(valid), 16'h1);

    // Clear in cycle t3 of a frame, fresh frame from t5
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    send_bit(1'b0);
    clear = 1'b0;
    check("mid_clr_outs", 16'({A, valid, par_err, frm_err, overrun}), 16'h0);
    send_bit(1'b1);
    check("mid_clr_no_pulse", 16'({valid, par_err, frm_err}), 16'h0);
    send_frame(7'b0111011, 1'b0, 1'b0);
    check("fresh_A", 16'(A), 16'h7);
    check("fresh_valid", 16'(valid), 16'h1);
    check("fresh_errs", 16'({par_err, frm_err, overrun}), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
